// File: rtl/vector_lane_serializer.sv
// vector_lane_serializer: drains packed result vectors one lane per cycle onto
// a narrow scalar stream. Two vector slots (active + pending) let the next
// vector's lane 0 follow the current vector's last lane with no bubble.
//
// state   | meaning
// --------+----------------------------------------------
// S_EMPTY | nothing held, lane stream idle
// S_DRAIN | active vector draining, pending slot free
// S_FULL  | active draining and pending vector waiting
module vector_lane_serializer #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 7,
  parameter int VECTOR  = 8,
  parameter int I_WIDTH = E_WIDTH + M_WIDTH + 1,
  parameter int VLEN    = I_WIDTH * VECTOR,
  parameter int IDX_W   = $clog2(VECTOR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic [VLEN-1:0]    vec_in,
  output logic               lane_valid,
  input  logic               lane_ready,
  output logic [I_WIDTH-1:0] lane_data,
  output logic [IDX_W-1:0]   lane_idx,
  output logic               lane_last,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_DRAIN = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR - 1);

  state_t            state_q, state_d;
  logic [VLEN-1:0]   active_q, active_d;
  logic [VLEN-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic vec_accept;
  logic lane_fire;
  logic last_fire;

  // Handshake qualifiers; everything driven out is a function of registered
  // state only, so no input reaches an output combinationally.
  always_comb begin
    vec_ready  = (state_q != S_FULL);
    lane_valid = (state_q != S_EMPTY);
    lane_data  = active_q[I_WIDTH*idx_q +: I_WIDTH];
    lane_idx   = idx_q;
    lane_last  = lane_valid & (idx_q == LAST_IDX);
    busy       = lane_valid;
    vec_accept = vec_valid & vec_ready;
    lane_fire  = lane_valid & lane_ready;
    last_fire  = lane_fire & (idx_q == LAST_IDX);
  end

  // Next-state logic: flush wins over any accept or fire in the same cycle.
  // An accept coinciding with the last fire loads active directly so the
  // pending slot is only ever used while the active vector is mid-drain.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    if (flush) begin
      state_d = S_EMPTY;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (vec_accept) begin
            active_d = vec_in;
            idx_d    = '0;
            state_d  = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_fire) begin
            idx_d = '0;
            if (vec_accept) begin
              active_d = vec_in;
              state_d  = S_DRAIN;
            end else begin
              state_d  = S_EMPTY;
            end
          end else begin
            if (vec_accept) begin
              pending_d = vec_in;
              state_d   = S_FULL;
            end
            if (lane_fire) begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        S_FULL: begin
          if (last_fire) begin
            active_d = pending_q;
            idx_d    = '0;
            state_d  = S_DRAIN;
          end else if (lane_fire) begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = S_EMPTY;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State and storage registers; reset clears both vector slots so no stale
  // payload is visible after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      active_q  <= '0;
      pending_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
    end
  end

endmodule
